// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: parallel word in over valid/ready, MSB-first serial
// bit stream out, with a one-word hold buffer so back-to-back words stream
// without an idle cycle between them.
module bit_stream_serializer #(
  parameter int WIDTH = 28,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] LOAD_DATA,
  input  logic [CNT_W-1:0] LOAD_LEN,
  output logic             X,
  output logic             X_VALID,
  output logic [CNT_W-1:0] BIT_IDX,
  output logic             DONE,
  output logic             BUSY
);

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;       // shift register, MSB is on X
  logic [CNT_W-1:0]   len_q, len_d;     // resolved length of current word
  logic [CNT_W-1:0]   idx_q, idx_d;     // bit index within current word
  logic               hfull_q, hfull_d;
  logic [WIDTH-1:0]   hdata_q, hdata_d;
  logic [CNT_W-1:0]   hlen_q, hlen_d;

  logic [CNT_W-1:0]   in_len;
  logic               xfer;
  logic               last;

  // Zero or out-of-range lengths mean a full word.
  assign in_len = (LOAD_LEN == '0 || LOAD_LEN > WIDTH_C) ? WIDTH_C : LOAD_LEN;
  assign xfer   = LOAD_VALID & ~hfull_q;
  assign last   = (idx_q == len_q - ONE_C);

  // State, datapath and hold-buffer registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      hfull_q <= 1'b0;
      hdata_q <= '0;
      hlen_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      hfull_q <= hfull_d;
      hdata_q <= hdata_d;
      hlen_q  <= hlen_d;
    end
  end

  // Next-state: load, shift, refill from hold buffer or bypass, or go idle.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    len_d   = len_q;
    idx_d   = idx_q;
    hfull_d = hfull_q;
    hdata_d = hdata_q;
    hlen_d  = hlen_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SHIFT;
          sh_d    = LOAD_DATA;
          len_d   = in_len;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        if (!last) begin
          sh_d  = sh_q << 1;
          idx_d = idx_q + ONE_C;
          if (xfer) begin
            hfull_d = 1'b1;
            hdata_d = LOAD_DATA;
            hlen_d  = in_len;
          end
        end else if (hfull_q) begin
          // Held word follows immediately; hold empties and ready returns.
          sh_d    = hdata_q;
          len_d   = hlen_q;
          idx_d   = '0;
          hfull_d = 1'b0;
        end else if (xfer) begin
          // Hold empty: the incoming word bypasses straight into the shifter.
          sh_d  = LOAD_DATA;
          len_d = in_len;
          idx_d = '0;
        end else begin
          state_d = IDLE;
          sh_d    = '0;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; nothing passes through from inputs.
  assign X_VALID    = (state_q == SHIFT);
  assign X          = X_VALID & sh_q[WIDTH-1];
  assign BIT_IDX    = idx_q;
  assign DONE       = X_VALID & last;
  assign BUSY       = X_VALID | hfull_q;
  assign LOAD_READY = ~hfull_q;

endmodule
